// File: rtl/dfi_cmd_arbiter.sv
// dfi_cmd_arbiter: the single owner of the DFI command path to the PHY.
// The initialization stream is passed through until init completes. After that
// the scheduler stream is passed through, and all-bank refresh sequences
// (PREA, then one or more REFs) are inserted from a tREFI timer.
// Optional feature macro: DFI_CMD_ARBITER_REF_POSTPONE_EN. When it is defined,
// refresh debt may build up to MAX_POSTPONE while the scheduler is busy and then
// drains in one burst. When it is undefined, refresh is forced on every tick.
module dfi_cmd_arbiter #(
  parameter int NUM_PHASES   = 4,
  parameter int MAX_POSTPONE = 8,
  parameter int ADDR_W       = 14,
  parameter int BANK_W       = 3,
  parameter int CS_W         = 1
) (
  input  logic                                i_core_clk,
  input  logic                                i_core_rst,
  input  logic                                i_ddr_init_done,
  input  logic [15:0]                         i_cfg_trefi,
  input  logic [15:0]                         i_cfg_trp,
  input  logic [15:0]                         i_cfg_trfc,
  input  logic [NUM_PHASES-1:0][ADDR_W-1:0]   i_init_address,
  input  logic [NUM_PHASES-1:0][BANK_W-1:0]   i_init_bank,
  input  logic [NUM_PHASES-1:0][CS_W-1:0]     i_init_cs_n,
  input  logic [NUM_PHASES-1:0]               i_init_ras_n,
  input  logic [NUM_PHASES-1:0]               i_init_cas_n,
  input  logic [NUM_PHASES-1:0]               i_init_we_n,
  input  logic [NUM_PHASES-1:0]               i_init_cke,
  input  logic [NUM_PHASES-1:0]               i_init_reset_n,
  input  logic [NUM_PHASES-1:0]               i_init_odt,
  input  logic                                i_init_dram_clk_disable,
  input  logic [NUM_PHASES-1:0][ADDR_W-1:0]   i_sched_address,
  input  logic [NUM_PHASES-1:0][BANK_W-1:0]   i_sched_bank,
  input  logic [NUM_PHASES-1:0][CS_W-1:0]     i_sched_cs_n,
  input  logic [NUM_PHASES-1:0]               i_sched_ras_n,
  input  logic [NUM_PHASES-1:0]               i_sched_cas_n,
  input  logic [NUM_PHASES-1:0]               i_sched_we_n,
  input  logic [NUM_PHASES-1:0]               i_sched_cke,
  input  logic [NUM_PHASES-1:0]               i_sched_reset_n,
  input  logic [NUM_PHASES-1:0]               i_sched_odt,
  input  logic                                i_sched_dram_clk_disable,
  input  logic                                i_sched_idle,
  output logic                                o_sched_hold,
  output logic [3:0]                          o_ref_pending,
  output logic [NUM_PHASES-1:0][ADDR_W-1:0]   o_phy_address,
  output logic [NUM_PHASES-1:0][BANK_W-1:0]   o_phy_bank,
  output logic [NUM_PHASES-1:0][CS_W-1:0]     o_phy_cs_n,
  output logic [NUM_PHASES-1:0]               o_phy_ras_n,
  output logic [NUM_PHASES-1:0]               o_phy_cas_n,
  output logic [NUM_PHASES-1:0]               o_phy_we_n,
  output logic [NUM_PHASES-1:0]               o_phy_cke,
  output logic [NUM_PHASES-1:0]               o_phy_reset_n,
  output logic [NUM_PHASES-1:0]               o_phy_odt,
  output logic                                o_phy_dram_clk_disable
);

  // ref_pending is 4 bits wide and PREA needs address bit 10.
  if (MAX_POSTPONE < 1 || MAX_POSTPONE > 15) begin : g_bad_postpone
    $error("MAX_POSTPONE must be in 1..15");
  end
  if (ADDR_W < 11) begin : g_bad_addr
    $error("ADDR_W must be at least 11");
  end

`ifdef DFI_CMD_ARBITER_REF_POSTPONE_EN
  localparam logic [3:0] LP_LIMIT = 4'(MAX_POSTPONE);
`else
  localparam logic [3:0] LP_LIMIT = 4'd1;
`endif

  typedef struct packed {
    logic [NUM_PHASES-1:0][ADDR_W-1:0] address;
    logic [NUM_PHASES-1:0][BANK_W-1:0] bank;
    logic [NUM_PHASES-1:0][CS_W-1:0]   cs_n;
    logic [NUM_PHASES-1:0]             ras_n;
    logic [NUM_PHASES-1:0]             cas_n;
    logic [NUM_PHASES-1:0]             we_n;
    logic [NUM_PHASES-1:0]             cke;
    logic [NUM_PHASES-1:0]             reset_n;
    logic [NUM_PHASES-1:0]             odt;
    logic                              dram_clk_disable;
  } dfi_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RUN,
    ST_REF_HOLD,
    ST_REF_PREA,
    ST_REF_WAIT_RP,
    ST_REF_ISSUE,
    ST_REF_WAIT_RFC
  } state_t;

  // Reset image: no command, CKE low, DRAM held in reset.
  function automatic dfi_t f_reset_word();
    dfi_t c;
    c       = '0;
    c.cs_n  = '1;
    c.ras_n = '1;
    c.cas_n = '1;
    c.we_n  = '1;
    return c;
  endfunction

  // All-phase NOP with the device powered and out of reset.
  function automatic dfi_t f_nop();
    dfi_t c;
    c         = f_reset_word();
    c.cke     = '1;
    c.reset_n = '1;
    return c;
  endfunction

  // Precharge-all on phase 0 to every rank.
  function automatic dfi_t f_prea();
    dfi_t c;
    c                = f_nop();
    c.cs_n[0]        = '0;
    c.ras_n[0]       = 1'b0;
    c.we_n[0]        = 1'b0;
    c.address[0][10] = 1'b1;
    return c;
  endfunction

  // All-bank refresh on phase 0 to every rank.
  function automatic dfi_t f_ref();
    dfi_t c;
    c          = f_nop();
    c.cs_n[0]  = '0;
    c.ras_n[0] = 1'b0;
    c.cas_n[0] = 1'b0;
    return c;
  endfunction

  dfi_t        w_init;
  dfi_t        w_sched;
  dfi_t        r_phy;
  state_t      r_state;
  logic        r_hold;
  logic [3:0]  r_pending;
  logic [15:0] r_timer;
  logic [15:0] r_cnt;
  logic        w_tick;
  logic        w_dec;
  logic        w_want_ref;

  assign w_init  = '{address: i_init_address, bank: i_init_bank, cs_n: i_init_cs_n,
                     ras_n: i_init_ras_n, cas_n: i_init_cas_n, we_n: i_init_we_n,
                     cke: i_init_cke, reset_n: i_init_reset_n, odt: i_init_odt,
                     dram_clk_disable: i_init_dram_clk_disable};
  assign w_sched = '{address: i_sched_address, bank: i_sched_bank, cs_n: i_sched_cs_n,
                     ras_n: i_sched_ras_n, cas_n: i_sched_cas_n, we_n: i_sched_we_n,
                     cke: i_sched_cke, reset_n: i_sched_reset_n, odt: i_sched_odt,
                     dram_clk_disable: i_sched_dram_clk_disable};

  assign w_tick     = (r_state != ST_INIT) && (i_cfg_trefi != 16'd0) &&
                      (r_timer >= i_cfg_trefi - 16'd1);
  assign w_dec      = (r_state == ST_REF_ISSUE);
  assign w_want_ref = (r_pending != 4'd0) && (i_sched_idle || (r_pending >= LP_LIMIT));

  // Refresh interval timer; idle in INIT and when tREFI is zero.
  always_ff @(posedge i_core_clk) begin
    if (i_core_rst || r_state == ST_INIT || i_cfg_trefi == 16'd0) begin
      r_timer <= 16'd0;
    end else if (w_tick) begin
      r_timer <= 16'd0;
    end else begin
      r_timer <= r_timer + 16'd1;
    end
  end

  // Refresh debt: tick adds, REF issue subtracts, both together cancel.
  always_ff @(posedge i_core_clk) begin
    if (i_core_rst) begin
      r_pending <= 4'd0;
    end else begin
      case ({w_tick, w_dec})
        2'b10:   if (r_pending < LP_LIMIT) r_pending <= r_pending + 4'd1;
        2'b01:   if (r_pending != 4'd0) r_pending <= r_pending - 4'd1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Command-path FSM; each edge registers the output of the state being entered,
  // except that the RUN->REF_HOLD edge still forwards the scheduler word.
  always_ff @(posedge i_core_clk) begin
    if (i_core_rst) begin
      r_state <= ST_INIT;
      r_hold  <= 1'b1;
      r_cnt   <= 16'd0;
      r_phy   <= f_reset_word();
    end else begin
      case (r_state)
        ST_INIT: begin
          if (i_ddr_init_done) begin
            r_state <= ST_RUN;
            r_hold  <= 1'b0;
            r_phy   <= w_sched;
          end else begin
            r_hold  <= 1'b1;
            r_phy   <= w_init;
          end
        end
        ST_RUN: begin
          r_phy <= w_sched;
          if (w_want_ref) begin
            r_state <= ST_REF_HOLD;
            r_hold  <= 1'b1;
          end else begin
            r_hold  <= 1'b0;
          end
        end
        ST_REF_HOLD: begin
          if (i_sched_idle) begin
            r_state <= ST_REF_PREA;
            r_phy   <= f_prea();
          end else begin
            r_phy   <= f_nop();
          end
        end
        ST_REF_PREA: begin
          r_state <= ST_REF_WAIT_RP;
          r_cnt   <= 16'd1;
          r_phy   <= f_nop();
        end
        ST_REF_WAIT_RP: begin
          if (r_cnt >= i_cfg_trp) begin
            r_state <= ST_REF_ISSUE;
            r_phy   <= f_ref();
          end else begin
            r_cnt   <= r_cnt + 16'd1;
            r_phy   <= f_nop();
          end
        end
        ST_REF_ISSUE: begin
          r_state <= ST_REF_WAIT_RFC;
          r_cnt   <= 16'd1;
          r_phy   <= f_nop();
        end
        ST_REF_WAIT_RFC: begin
          if (r_cnt >= i_cfg_trfc) begin
            if (r_pending != 4'd0) begin
              r_state <= ST_REF_ISSUE;
              r_phy   <= f_ref();
            end else begin
              r_state <= ST_RUN;
              r_hold  <= 1'b0;
              r_phy   <= w_sched;
            end
          end else begin
            r_cnt   <= r_cnt + 16'd1;
            r_phy   <= f_nop();
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_hold  <= 1'b1;
          r_phy   <= f_reset_word();
        end
      endcase
    end
  end

  assign o_sched_hold           = r_hold;
  assign o_ref_pending          = r_pending;
  assign o_phy_address          = r_phy.address;
  assign o_phy_bank             = r_phy.bank;
  assign o_phy_cs_n             = r_phy.cs_n;
  assign o_phy_ras_n            = r_phy.ras_n;
  assign o_phy_cas_n            = r_phy.cas_n;
  assign o_phy_we_n             = r_phy.we_n;
  assign o_phy_cke              = r_phy.cke;
  assign o_phy_reset_n          = r_phy.reset_n;
  assign o_phy_odt              = r_phy.odt;
  assign o_phy_dram_clk_disable = r_phy.dram_clk_disable;

endmodule

// File: tb/tb_dfi_cmd_arbiter.sv
// Directed bench for dfi_cmd_arbiter: init handoff, basic refresh, reset in the
// middle of a sequence, tick/issue collision and refresh postponement.
module tb_dfi_cmd_arbiter;
  localparam int NP = 4;
  localparam int AW = 14;
  localparam int BW = 3;
  localparam int CW = 1;

`ifdef DFI_CMD_ARBITER_REF_POSTPONE_EN
  localparam int EXP_LIMIT = 8;
`else
  localparam int EXP_LIMIT = 1;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    done;
  logic [15:0]             trefi, trp, trfc;
  logic [NP-1:0][AW-1:0]   init_address, sched_address;
  logic [NP-1:0][BW-1:0]   init_bank, sched_bank;
  logic [NP-1:0][CW-1:0]   init_cs_n, sched_cs_n;
  logic [NP-1:0]           init_ras_n, init_cas_n, init_we_n, init_cke, init_reset_n, init_odt;
  logic [NP-1:0]           sched_ras_n, sched_cas_n, sched_we_n, sched_cke, sched_reset_n, sched_odt;
  logic                    init_dcd, sched_dcd;
  logic                    idle;
  logic                    hold;
  logic [3:0]              pend;
  logic [NP-1:0][AW-1:0]   phy_address;
  logic [NP-1:0][BW-1:0]   phy_bank;
  logic [NP-1:0][CW-1:0]   phy_cs_n;
  logic [NP-1:0]           phy_ras_n, phy_cas_n, phy_we_n, phy_cke, phy_reset_n, phy_odt;
  logic                    phy_dcd;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  int n_ref, n_prea, gap_err, max_pend, last_ref;

  dfi_cmd_arbiter #(.NUM_PHASES(NP), .MAX_POSTPONE(8), .ADDR_W(AW), .BANK_W(BW), .CS_W(CW)) dut (
    .i_core_clk(clk), .i_core_rst(rst), .i_ddr_init_done(done),
    .i_cfg_trefi(trefi), .i_cfg_trp(trp), .i_cfg_trfc(trfc),
    .i_init_address(init_address), .i_init_bank(init_bank), .i_init_cs_n(init_cs_n),
    .i_init_ras_n(init_ras_n), .i_init_cas_n(init_cas_n), .i_init_we_n(init_we_n),
    .i_init_cke(init_cke), .i_init_reset_n(init_reset_n), .i_init_odt(init_odt),
    .i_init_dram_clk_disable(init_dcd),
    .i_sched_address(sched_address), .i_sched_bank(sched_bank), .i_sched_cs_n(sched_cs_n),
    .i_sched_ras_n(sched_ras_n), .i_sched_cas_n(sched_cas_n), .i_sched_we_n(sched_we_n),
    .i_sched_cke(sched_cke), .i_sched_reset_n(sched_reset_n), .i_sched_odt(sched_odt),
    .i_sched_dram_clk_disable(sched_dcd),
    .i_sched_idle(idle), .o_sched_hold(hold), .o_ref_pending(pend),
    .o_phy_address(phy_address), .o_phy_bank(phy_bank), .o_phy_cs_n(phy_cs_n),
    .o_phy_ras_n(phy_ras_n), .o_phy_cas_n(phy_cas_n), .o_phy_we_n(phy_we_n),
    .o_phy_cke(phy_cke), .o_phy_reset_n(phy_reset_n), .o_phy_odt(phy_odt),
    .o_phy_dram_clk_disable(phy_dcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Phase-0 command as {cs_n, ras_n, cas_n, we_n}: NOP=F, PREA=2, REF=1, MRS=0.
  function automatic logic [3:0] cmd0();
    return {phy_cs_n[0][0], phy_ras_n[0], phy_cas_n[0], phy_we_n[0]};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_en   = 1'b0;
    n_ref    = 0;
    n_prea   = 0;
    gap_err  = 0;
    max_pend = 0;
    last_ref = 0;
    mon_en   = 1'b1;
  endtask

  // Reset, then raise init_done; returns in the first RUN cycle.
  task automatic reset_and_handoff();
    rst  = 1'b1;
    done = 1'b0;
    tick(2);
    rst  = 1'b0;
    tick(2);
    done = 1'b1;
    tick(1);
  endtask

  // Observe phy commands at the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cmd0() == 4'h1) begin
        if (n_ref > 0 && (cyc - last_ref) != 11) gap_err++;
        last_ref = cyc;
        n_ref++;
      end
      if (cmd0() == 4'h2 && phy_address[0][10]) n_prea++;
      if (int'(pend) > max_pend) max_pend = int'(pend);
    end
  end

  initial begin
    rst = 1'b1; done = 1'b0; idle = 1'b1;
    trefi = 16'd100; trp = 16'd3; trfc = 16'd10;
    init_address = '0; init_bank = '0; init_cs_n = '1;
    init_ras_n = '1; init_cas_n = '1; init_we_n = '1;
    init_cke = '1; init_reset_n = '1; init_odt = '0; init_dcd = 1'b0;
    sched_address = '0; sched_address[0] = 14'h0AAA; sched_bank = '0; sched_cs_n = '1;
    sched_ras_n = '1; sched_cas_n = '1; sched_we_n = '1;
    sched_cke = '1; sched_reset_n = '1; sched_odt = '0; sched_dcd = 1'b0;

    // Reset values
    tick(3);
    check_vec("rst_cs_n", 32'(phy_cs_n), 32'hF);
    check_vec("rst_cmd", 32'(cmd0()), 32'hF);
    check_vec("rst_cke", 32'(phy_cke), 32'h0);
    check_vec("rst_reset_n", 32'(phy_reset_n), 32'h0);
    check_vec("rst_addr0", 32'(phy_address[0]), 32'h0);
    check_vec("rst_hold", 32'(hold), 32'h1);
    check_vec("rst_pend", 32'(pend), 32'h0);

    // Init passthrough of an MRS, then handoff
    rst = 1'b0;
    tick(2);
    init_cs_n[0] = '0; init_ras_n[0] = 1'b0; init_cas_n[0] = 1'b0; init_we_n[0] = 1'b0;
    init_bank[0] = 3'd3; init_address[0] = 14'h123;
    tick(1);
    check_vec("mrs_cmd", 32'(cmd0()), 32'h0);
    check_vec("mrs_addr", 32'(phy_address[0]), 32'h123);
    check_vec("mrs_bank", 32'(phy_bank[0]), 32'h3);
    check_vec("init_hold", 32'(hold), 32'h1);
    init_cs_n = '1; init_ras_n = '1; init_cas_n = '1; init_we_n = '1;
    init_bank = '0; init_address = '0;
    tick(1);
    done = 1'b1;
    tick(1);
    // First RUN cycle R
    check_vec("handoff_addr", 32'(phy_address[0]), 32'hAAA);
    check_vec("handoff_hold", 32'(hold), 32'h0);

    // Basic refresh: tREFI=100, tRP=3, tRFC=10
    tick(99);
    check_vec("pend_before_tick", 32'(pend), 32'h0);
    tick(1);
    check_vec("pend_after_tick", 32'(pend), 32'h1);
    check_vec("hold_at_decision", 32'(hold), 32'h0);
    tick(1);
    check_vec("hold_rise", 32'(hold), 32'h1);
    check_vec("fwd_one_more", 32'(phy_address[0]), 32'hAAA);
    tick(1);
    check_vec("prea_cmd", 32'(cmd0()), 32'h2);
    check_vec("prea_a10", 32'(phy_address[0]), 32'h400);
    tick(3);
    check_vec("wait_rp_nop", 32'(cmd0()), 32'hF);
    tick(1);
    check_vec("ref_cmd", 32'(cmd0()), 32'h1);
    check_vec("ref_pend", 32'(pend), 32'h1);
    tick(1);
    check_vec("pend_drained", 32'(pend), 32'h0);
    tick(9);
    check_vec("hold_in_rfc", 32'(hold), 32'h1);
    tick(1);
    check_vec("run_hold_fall", 32'(hold), 32'h0);
    check_vec("run_resume_addr", 32'(phy_address[0]), 32'hAAA);

    // Reset in REF_WAIT_RFC of the second sequence
    tick(89);
    check_vec("ref2_cmd", 32'(cmd0()), 32'h1);
    tick(1);
    rst  = 1'b1;
    done = 1'b0;
    tick(1);
    check_vec("midrst_cs_n", 32'(phy_cs_n), 32'hF);
    check_vec("midrst_cke", 32'(phy_cke), 32'h0);
    check_vec("midrst_reset_n", 32'(phy_reset_n), 32'h0);
    check_vec("midrst_hold", 32'(hold), 32'h1);
    check_vec("midrst_pend", 32'(pend), 32'h0);
    rst = 1'b0;
    tick(1);
    mon_clear();
    tick(150);
    check_vec("no_ref_in_init", 32'(n_ref), 32'h0);
    done = 1'b1;
    tick(1);
    mon_clear();
    tick(105);
    check_vec("no_ref_before_trefi", 32'(n_ref), 32'h0);
    tick(1);
    check_vec("ref_after_reinit", 32'(cmd0()), 32'h1);
    mon_en = 1'b0;

    // Timer tick in the same cycle as REF issue: tREFI = tRP + 4
    trefi = 16'd7;
    reset_and_handoff();
    tick(13);
    check_vec("coll_ref_cmd", 32'(cmd0()), 32'h1);
    check_vec("coll_pend_before", 32'(pend), 32'h1);
    tick(1);
    check_vec("coll_pend_after", 32'(pend), 32'h1);
    trefi = 16'd0;
    tick(10);
    check_vec("coll_second_ref", 32'(cmd0()), 32'h1);
    tick(1);
    check_vec("coll_pend_zero", 32'(pend), 32'h0);
    tick(10);
    check_vec("coll_run_hold", 32'(hold), 32'h0);

    // Postponement: scheduler busy for 9 x tREFI, then idle
    trefi = 16'd100;
    idle  = 1'b0;
    reset_and_handoff();
    mon_clear();
    tick(900);
    check_vec("busy_no_ref", 32'(n_ref), 32'h0);
    check_vec("busy_max_pend", 32'(max_pend), 32'(EXP_LIMIT));
    check_vec("busy_hold", 32'(hold), 32'h1);
    mon_clear();
    idle = 1'b1;
    tick(100);
    check_vec("drain_prea_count", 32'(n_prea), 32'h1);
    check_vec("drain_ref_count", 32'(n_ref), 32'(EXP_LIMIT));
    check_vec("drain_ref_gap", 32'(gap_err), 32'h0);
    check_vec("drain_max_pend", 32'(max_pend), 32'(EXP_LIMIT));
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
